sync_pulse_gen: RTL and testbench
=================================

SYNC_PULSE_GEN -- requirements
Module: sync_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, period counter width.
REQ-002 SHALL have parameter PW_W, default 8, pulse-width field width.
REQ-003 SHALL have parameter N_CH, default 4, scan channels; power of 2, >=2.
REQ-004 SHALL have parameter RST_PERIOD, default 4095, period after reset (cycles minus 1).
REQ-005 SHALL have parameter RST_WIDTH, default 2, pulse width after reset.
REQ-006 SHALL have parameter STOP_MODE, default 0; 0 = stop immediately, 1 = finish current period.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port en, input, 1, run request.
REQ-010 SHALL have port cfg_valid, input, 1, new configuration offered.
REQ-011 SHALL have port cfg_ready, output, 1, configuration can be accepted.
REQ-012 SHALL have port cfg_period, input, CNT_W, period minus 1.
REQ-013 SHALL have port cfg_width, input, PW_W, pulse high cycles.
REQ-014 SHALL have port tick_o, output, 1, sync pulse.
REQ-015 SHALL have port sel_onehot, output, N_CH, active scan channel.
REQ-016 SHALL have port sel_idx, output, $clog2(N_CH), active channel index.
REQ-017 SHALL have port frame_o, output, 1, one-cycle pulse at the start of each channel-0 period.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN.
REQ-019 SHALL leave IDLE for RUN on the edge sampling en=1; cnt=0 in the first RUN cycle.
REQ-020 SHALL count cnt 0..period_act in RUN/DRAIN and wrap to 0, giving period_act+1 cycles per period.
REQ-021 SHALL drive tick_o high exactly in RUN/DRAIN cycles where cnt < width_act, from a flop (glitch-free).
REQ-022 SHALL hold tick_o high continuously when width_act > period_act; width_act=0 never pulses.
REQ-023 SHALL advance sel_idx/sel_onehot by one channel, modulo N_CH, on each wrap; N_CH-1 wraps to 0.
REQ-024 SHALL assert frame_o in the first cycle of every period where sel_idx=0, including the first RUN cycle.
REQ-025 SHALL accept configuration on a cycle with cfg_valid and cfg_ready both high, into a shadow register.
REQ-026 SHALL drive cfg_ready = not pending; pending sets on accept in RUN/DRAIN and clears at the next wrap.
REQ-027 SHALL apply shadow values to period_act/width_act at the next wrap; in IDLE, apply immediately with no pending.
REQ-028 SHALL treat an accept on the wrap cycle itself as applying at the following wrap.
REQ-029 SHALL, with STOP_MODE=0 and en=0 in RUN, go to IDLE next edge: cnt=0, tick_o=0, sel_idx=0.
REQ-030 SHALL, with STOP_MODE=1 and en=0 in RUN, enter DRAIN and complete the period, then go to IDLE on the wrap.
REQ-031 SHALL return from DRAIN to RUN without disturbing cnt or sel when en=1 again.
REQ-032 SHALL support period_act=0, in which every cycle is a wrap.

Reset
REQ-033 SHALL, on rst_n=0 asynchronously, set: state IDLE, cnt 0, tick_o 0, frame_o 0, sel_idx 0, sel_onehot 1, period_act RST_PERIOD, width_act RST_WIDTH, pending 0, cfg_ready 1.
REQ-034 SHALL discard a pending configuration on reset mid-operation.

Structure
REQ-035 SHALL place the state enum, RST_PERIOD/RST_WIDTH defaults and the STOP_MODE encodings in shared package sync_pkg.
REQ-036 SHALL isolate the shadow/pending/apply logic in sub-module sync_cfg_shadow.

Verification
REQ-037 SHALL check: reset defaults, en=1 -> tick_o high for 2 cycles every 4096; sel_idx 0,1,2,3,0; frame_o every 16384 cycles.
REQ-038 SHALL check: in IDLE, cfg period=9 width=3 -> tick high 3 of every 10 cycles from the first RUN cycle.
REQ-039 SHALL check: in RUN at cnt=5 of period 9, cfg period=4 -> cfg_ready low, old period completes, then 5-cycle periods, cfg_ready high.
REQ-040 SHALL check: width=12, period=9 -> tick_o constantly high; width=0 -> tick_o constantly low.
REQ-041 SHALL check: STOP_MODE=1, en drops at cnt=3 of period 9 -> 6 more cycles, then IDLE; re-raising en at cnt=7 continues seamlessly.
REQ-042 SHALL check: rst_n pulsed mid-period with pending config -> all outputs at reset values in the same cycle; pending config never applied.

Source files
------------

// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared definitions for the sync pulse generator: controller state encoding,
// the reset-time period/width defaults and the stop-behaviour encodings.
// -----------------------------------------------------------------------------
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sync_state_e;

    // Period is stored as (cycles - 1); width is the number of high cycles.
    localparam int RST_PERIOD_DEF = 4095;
    localparam int RST_WIDTH_DEF  = 2;

    // Behaviour when en drops while running.
    localparam int STOP_IMMEDIATE = 0;  // return to IDLE on the next edge
    localparam int STOP_FINISH    = 1;  // finish the current period first

endpackage

// File: rtl/sync_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// sync_pulse_gen_if
// Control/configuration bus of the sync pulse generator.
//   en          run request
//   cfg_valid   new configuration offered
//   cfg_ready   configuration can be accepted
//   cfg_period  period minus 1
//   cfg_width   pulse high cycles
//   tick_o      sync pulse
//   sel_onehot  active scan channel (one-hot)
//   sel_idx     active scan channel index
//   frame_o     one-cycle pulse at the start of each channel-0 period
// Handshake: a configuration transfers on every rising edge where cfg_valid
// and cfg_ready are both high; cfg_period/cfg_width must be stable while
// cfg_valid is high, and cfg_ready does not depend on cfg_valid.
// The slave modport is the generator side, master is the controller side.
// -----------------------------------------------------------------------------
interface sync_pulse_gen_if #(
    parameter int CNT_W = 16,
    parameter int PW_W  = 8,
    parameter int N_CH  = 4
);
    localparam int SEL_W = $clog2(N_CH);

    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_period;
    logic [PW_W-1:0]   cfg_width;
    logic              tick_o;
    logic [N_CH-1:0]   sel_onehot;
    logic [SEL_W-1:0]  sel_idx;
    logic              frame_o;

    modport slave (
        input  en, cfg_valid, cfg_period, cfg_width,
        output cfg_ready, tick_o, sel_onehot, sel_idx, frame_o
    );

    modport master (
        output en, cfg_valid, cfg_period, cfg_width,
        input  cfg_ready, tick_o, sel_onehot, sel_idx, frame_o
    );
endinterface

// File: rtl/sync_cfg_shadow.sv
// -----------------------------------------------------------------------------
// sync_cfg_shadow
// Holds the active period/width and a one-deep shadow for updates that arrive
// while the generator is running, so a period is never cut short or stretched
// by a mid-period reconfiguration.
//   clk, rst_n   clock, asynchronous active-low reset
//   idle         generator is currently in IDLE: accepts apply at once
//   to_idle      generator leaves RUN/DRAIN for IDLE on this edge
//   apply        period boundary (wrap) or stop on this edge
//   cfg_valid    configuration offered
//   cfg_period   offered period minus 1
//   cfg_width    offered pulse width
//   cfg_ready    no configuration is waiting in the shadow
//   period_act   active period minus 1
//   width_nxt    active width as it will be after this edge
// -----------------------------------------------------------------------------
module sync_cfg_shadow #(
    parameter int CNT_W      = 16,
    parameter int PW_W       = 8,
    parameter int RST_PERIOD = 4095,
    parameter int RST_WIDTH  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idle,
    input  logic             to_idle,
    input  logic             apply,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [PW_W-1:0]  cfg_width,
    output logic             cfg_ready,
    output logic [CNT_W-1:0] period_act,
    output logic [PW_W-1:0]  width_nxt
);
    logic [PW_W-1:0]  width_act;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] shadow_period, shadow_period_nxt;
    logic [PW_W-1:0]  shadow_width, shadow_width_nxt;
    logic             pending, pending_nxt;
    logic             accept;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & ~pending;

    always_comb begin
        period_nxt        = period_act;
        width_nxt         = width_act;
        shadow_period_nxt = shadow_period;
        shadow_width_nxt  = shadow_width;
        pending_nxt       = pending;
        if (pending) begin
            // No accept can coincide with a pending entry (cfg_ready is low).
            if (apply) begin
                period_nxt  = shadow_period;
                width_nxt   = shadow_width;
                pending_nxt = 1'b0;
            end
        end else if (accept) begin
            if (idle || to_idle) begin
                // Nothing is running (or about to run) on the old values.
                period_nxt = cfg_period;
                width_nxt  = cfg_width;
            end else begin
                // Accept on a wrap edge also lands here: it applies at the
                // following wrap, not this one.
                shadow_period_nxt = cfg_period;
                shadow_width_nxt  = cfg_width;
                pending_nxt       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act    <= CNT_W'(RST_PERIOD);
            width_act     <= PW_W'(RST_WIDTH);
            shadow_period <= '0;
            shadow_width  <= '0;
            pending       <= 1'b0;
        end else begin
            period_act    <= period_nxt;
            width_act     <= width_nxt;
            shadow_period <= shadow_period_nxt;
            shadow_width  <= shadow_width_nxt;
            pending       <= pending_nxt;
        end
    end
endmodule

// File: rtl/sync_pulse_gen.sv
// -----------------------------------------------------------------------------
// sync_pulse_gen
// Periodic sync pulse generator with a scanning channel selector. Each period
// lasts period_act+1 cycles; tick_o is high for the first width_act cycles of
// it. Every period boundary advances the scan channel; frame_o marks the start
// of each channel-0 period.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          control/config bus (slave side), see sync_pulse_gen_if
//   dbg_state    current controller state
// N_CH must be a power of two (>= 2) so the channel index wraps naturally.
// -----------------------------------------------------------------------------
module sync_pulse_gen
    import sync_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int PW_W       = 8,
    parameter int N_CH       = 4,
    parameter int RST_PERIOD = RST_PERIOD_DEF,
    parameter int RST_WIDTH  = RST_WIDTH_DEF,
    parameter int STOP_MODE  = STOP_IMMEDIATE
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_pulse_gen_if.slave bus,
    output sync_state_e     dbg_state
);
    localparam int SEL_W = $clog2(N_CH);

    sync_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] sel_idx_q, sel_nxt;
    logic [N_CH-1:0]  sel_onehot_q;
    logic             tick_q, frame_q;
    logic             wrap, to_idle, apply;
    logic [CNT_W-1:0] period_act;
    logic [PW_W-1:0]  width_nxt;

    sync_cfg_shadow #(
        .CNT_W      (CNT_W),
        .PW_W       (PW_W),
        .RST_PERIOD (RST_PERIOD),
        .RST_WIDTH  (RST_WIDTH)
    ) u_cfg (
        .clk        (clk),
        .rst_n      (rst_n),
        .idle       (state == IDLE),
        .to_idle    (to_idle),
        .apply      (apply),
        .cfg_valid  (bus.cfg_valid),
        .cfg_period (bus.cfg_period),
        .cfg_width  (bus.cfg_width),
        .cfg_ready  (bus.cfg_ready),
        .period_act (period_act),
        .width_nxt  (width_nxt)
    );

    assign wrap  = (state != IDLE) && (cnt == period_act);
    assign apply = wrap | to_idle;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_idx_q;
        to_idle   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                sel_nxt = '0;
                if (bus.en) state_nxt = RUN;
            end
            RUN, DRAIN: begin
                if (!bus.en && STOP_MODE == STOP_IMMEDIATE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    sel_nxt   = '0;
                    to_idle   = 1'b1;
                end else begin
                    // en decides between RUN and DRAIN; counting is shared.
                    state_nxt = bus.en ? RUN : DRAIN;
                    if (wrap) begin
                        cnt_nxt = '0;
                        if (bus.en) begin
                            sel_nxt = sel_idx_q + 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            sel_nxt   = '0;
                            to_idle   = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                sel_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from next-cycle values so they line up with
    // cnt/sel of the cycle they describe and cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sel_idx_q    <= '0;
            sel_onehot_q <= {{(N_CH-1){1'b0}}, 1'b1};
            tick_q       <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            sel_idx_q    <= sel_nxt;
            sel_onehot_q <= {{(N_CH-1){1'b0}}, 1'b1} << sel_nxt;
            // Zero-extend both sides so differing CNT_W/PW_W compare correctly.
            tick_q       <= (state_nxt != IDLE) &&
                            ({{PW_W{1'b0}}, cnt_nxt} < {{CNT_W{1'b0}}, width_nxt});
            frame_q      <= (state_nxt != IDLE) && (cnt_nxt == '0) && (sel_nxt == '0);
        end
    end

    assign bus.tick_o     = tick_q;
    assign bus.frame_o    = frame_q;
    assign bus.sel_idx    = sel_idx_q;
    assign bus.sel_onehot = sel_onehot_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_sync_pulse_gen.sv
module tb_sync_pulse_gen;
    import sync_pkg::*;

    localparam int CNT_W = 16;
    localparam int PW_W  = 8;
    localparam int N_CH  = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    sync_state_e dbg0, dbg1;
    int          checks = 0;
    int          errors = 0;

    sync_pulse_gen_if #(.CNT_W(CNT_W), .PW_W(PW_W), .N_CH(N_CH)) bus0 ();
    sync_pulse_gen_if #(.CNT_W(CNT_W), .PW_W(PW_W), .N_CH(N_CH)) bus1 ();

    sync_pulse_gen #(
        .CNT_W(CNT_W), .PW_W(PW_W), .N_CH(N_CH),
        .RST_PERIOD(RST_PERIOD_DEF), .RST_WIDTH(RST_WIDTH_DEF), .STOP_MODE(STOP_IMMEDIATE)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(dbg0));

    sync_pulse_gen #(
        .CNT_W(CNT_W), .PW_W(PW_W), .N_CH(N_CH),
        .RST_PERIOD(RST_PERIOD_DEF), .RST_WIDTH(RST_WIDTH_DEF), .STOP_MODE(STOP_FINISH)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cfg0_idle(input int period, input int width);
        bus0.cfg_period = CNT_W'(period);
        bus0.cfg_width  = PW_W'(width);
        bus0.cfg_valid  = 1'b1;
        step(1);
        bus0.cfg_valid  = 1'b0;
    endtask

    task automatic cfg1_idle(input int period, input int width);
        bus1.cfg_period = CNT_W'(period);
        bus1.cfg_width  = PW_W'(width);
        bus1.cfg_valid  = 1'b1;
        step(1);
        bus1.cfg_valid  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(2);
        checks++; if (bus0.tick_o !== 1'b0)        begin errors++; $display("FAIL rst0_tick: got %b exp 0", bus0.tick_o); end
        checks++; if (bus0.frame_o !== 1'b0)       begin errors++; $display("FAIL rst0_frame: got %b exp 0", bus0.frame_o); end
        checks++; if (bus0.sel_idx !== 2'd0)       begin errors++; $display("FAIL rst0_sel: got %0d exp 0", bus0.sel_idx); end
        checks++; if (bus0.sel_onehot !== 4'b0001) begin errors++; $display("FAIL rst0_onehot: got %b exp 0001", bus0.sel_onehot); end
        checks++; if (bus0.cfg_ready !== 1'b1)     begin errors++; $display("FAIL rst0_ready: got %b exp 1", bus0.cfg_ready); end
        checks++; if (dbg0 !== IDLE)               begin errors++; $display("FAIL rst0_state: got %0d exp %0d", dbg0, IDLE); end
        checks++; if (bus1.tick_o !== 1'b0)        begin errors++; $display("FAIL rst1_tick: got %b exp 0", bus1.tick_o); end
        checks++; if (bus1.sel_onehot !== 4'b0001) begin errors++; $display("FAIL rst1_onehot: got %b exp 0001", bus1.sel_onehot); end
        checks++; if (bus1.cfg_ready !== 1'b1)     begin errors++; $display("FAIL rst1_ready: got %b exp 1", bus1.cfg_ready); end
        checks++; if (dbg1 !== IDLE)               begin errors++; $display("FAIL rst1_state: got %0d exp %0d", dbg1, IDLE); end
        rst_n = 1'b1;
    endtask

    // Defaults: 4096-cycle periods, 2-cycle pulse, frame every 4 periods.
    task automatic test_default_run();
        int bad_tick, bad_sel, bad_frame, first_tick, first_sel, first_frame;
        logic exp_tick, exp_frame;
        logic [1:0] exp_sel;
        bad_tick = 0; bad_sel = 0; bad_frame = 0;
        first_tick = -1; first_sel = -1; first_frame = -1;
        bus0.en = 1'b1;
        step(1);
        for (int i = 0; i < 16390; i++) begin
            exp_tick  = (i % 4096) < 2;
            exp_sel   = 2'((i / 4096) % 4);
            exp_frame = (i % 16384) == 0;
            if (bus0.tick_o !== exp_tick) begin
                if (bad_tick == 0) first_tick = i;
                bad_tick++;
            end
            if (bus0.sel_idx !== exp_sel || bus0.sel_onehot !== (4'b0001 << exp_sel)) begin
                if (bad_sel == 0) first_sel = i;
                bad_sel++;
            end
            if (bus0.frame_o !== exp_frame) begin
                if (bad_frame == 0) first_frame = i;
                bad_frame++;
            end
            step(1);
        end
        checks++; if (bad_tick !== 0)  begin errors++; $display("FAIL default_tick: %0d bad cycles, first at %0d, exp 0", bad_tick, first_tick); end
        checks++; if (bad_sel !== 0)   begin errors++; $display("FAIL default_sel: %0d bad cycles, first at %0d, exp 0", bad_sel, first_sel); end
        checks++; if (bad_frame !== 0) begin errors++; $display("FAIL default_frame: %0d bad cycles, first at %0d, exp 0", bad_frame, first_frame); end
        bus0.en = 1'b0;
        step(1);
        checks++; if (dbg0 !== IDLE) begin errors++; $display("FAIL default_stop: got %0d exp %0d", dbg0, IDLE); end
    endtask

    // Configuration offered in IDLE applies at once: 3 of every 10 cycles.
    task automatic test_cfg_idle();
        int bad;
        logic exp_tick, exp_frame;
        logic [1:0] exp_sel;
        bad = 0;
        cfg0_idle(9, 3);
        checks++; if (bus0.cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_cfg_ready: got %b exp 1", bus0.cfg_ready); end
        bus0.en = 1'b1;
        step(1);
        for (int i = 0; i < 32; i++) begin
            exp_tick  = (i % 10) < 3;
            exp_sel   = 2'((i / 10) % 4);
            exp_frame = (i == 0);
            if (bus0.tick_o !== exp_tick || bus0.sel_idx !== exp_sel ||
                bus0.frame_o !== exp_frame || dbg0 !== RUN) begin
                if (bad == 0)
                    $display("FAIL idle_cfg_cycle%0d: tick %b sel %0d frame %b, exp tick %b sel %0d frame %b",
                             i, bus0.tick_o, bus0.sel_idx, bus0.frame_o, exp_tick, exp_sel, exp_frame);
                bad++;
            end
        end_loop_step: step(1);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_cfg_pattern: %0d bad cycles, exp 0", bad); end
    endtask

    // Continues from cycle 32 of the previous run (cnt 2, channel 3).
    task automatic test_stop_immediate();
        checks++; if (bus0.tick_o !== 1'b1 || bus0.sel_idx !== 2'd3) begin
            errors++; $display("FAIL stop_pre: tick %b sel %0d, exp tick 1 sel 3", bus0.tick_o, bus0.sel_idx);
        end
        bus0.en = 1'b0;
        step(1);
        checks++; if (dbg0 !== IDLE)               begin errors++; $display("FAIL stop_state: got %0d exp %0d", dbg0, IDLE); end
        checks++; if (bus0.tick_o !== 1'b0)        begin errors++; $display("FAIL stop_tick: got %b exp 0", bus0.tick_o); end
        checks++; if (bus0.sel_idx !== 2'd0)       begin errors++; $display("FAIL stop_sel: got %0d exp 0", bus0.sel_idx); end
        checks++; if (bus0.sel_onehot !== 4'b0001) begin errors++; $display("FAIL stop_onehot: got %b exp 0001", bus0.sel_onehot); end
        checks++; if (bus0.frame_o !== 1'b0)       begin errors++; $display("FAIL stop_frame: got %b exp 0", bus0.frame_o); end
    endtask

    // Period 9 running; at cnt 5 offer period 4 width 2.
    task automatic test_cfg_run();
        int bad;
        logic exp_tick, exp_ready, exp_frame;
        logic [1:0] exp_sel;
        bad = 0;
        cfg0_idle(9, 3);
        bus0.en = 1'b1;
        step(6);
        checks++; if (bus0.cfg_ready !== 1'b1) begin errors++; $display("FAIL run_cfg_ready_pre: got %b exp 1", bus0.cfg_ready); end
        bus0.cfg_period = 16'd4;
        bus0.cfg_width  = 8'd2;
        bus0.cfg_valid  = 1'b1;
        step(1);
        bus0.cfg_valid  = 1'b0;
        checks++; if (bus0.cfg_ready !== 1'b0) begin errors++; $display("FAIL run_cfg_ready_pending: got %b exp 0", bus0.cfg_ready); end
        for (int i = 6; i <= 30; i++) begin
            exp_ready = (i >= 10);
            exp_tick  = (i < 10) ? 1'b0 : (((i - 10) % 5) < 2);
            exp_sel   = (i < 10) ? 2'd0 : 2'((1 + (i - 10) / 5) % 4);
            exp_frame = (i == 25);
            if (bus0.cfg_ready !== exp_ready || bus0.tick_o !== exp_tick ||
                bus0.sel_idx !== exp_sel || bus0.frame_o !== exp_frame) begin
                if (bad == 0)
                    $display("FAIL run_cfg_cycle%0d: ready %b tick %b sel %0d frame %b, exp ready %b tick %b sel %0d frame %b",
                             i, bus0.cfg_ready, bus0.tick_o, bus0.sel_idx, bus0.frame_o,
                             exp_ready, exp_tick, exp_sel, exp_frame);
                bad++;
            end
            step(1);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL run_cfg_pattern: %0d bad cycles, exp 0", bad); end
        bus0.en = 1'b0;
        step(1);
    endtask

    // Accept on the wrap cycle itself: the next period still uses the old values.
    task automatic test_cfg_wrap();
        int bad;
        logic exp_tick, exp_ready, exp_frame;
        logic [1:0] exp_sel;
        bad = 0;
        cfg0_idle(4, 1);
        bus0.en = 1'b1;
        step(1);
        for (int i = 0; i <= 18; i++) begin
            exp_ready = !(i >= 5 && i <= 9);
            exp_tick  = (i < 10) ? ((i % 5) == 0) : (((i - 10) % 3) == 0);
            exp_sel   = (i < 5) ? 2'd0 : (i < 10) ? 2'd1 : (i < 13) ? 2'd2 : (i < 16) ? 2'd3 : 2'd0;
            exp_frame = (i == 0) || (i == 16);
            if (bus0.cfg_ready !== exp_ready || bus0.tick_o !== exp_tick ||
                bus0.sel_idx !== exp_sel || bus0.frame_o !== exp_frame) begin
                if (bad == 0)
                    $display("FAIL wrap_cfg_cycle%0d: ready %b tick %b sel %0d frame %b, exp ready %b tick %b sel %0d frame %b",
                             i, bus0.cfg_ready, bus0.tick_o, bus0.sel_idx, bus0.frame_o,
                             exp_ready, exp_tick, exp_sel, exp_frame);
                bad++;
            end
            if (i == 4) begin
                bus0.cfg_period = 16'd2;
                bus0.cfg_width  = 8'd1;
                bus0.cfg_valid  = 1'b1;
            end
            if (i == 5) bus0.cfg_valid = 1'b0;
            step(1);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_cfg_pattern: %0d bad cycles, exp 0", bad); end
        bus0.en = 1'b0;
        step(1);
    endtask

    task automatic test_width_extremes();
        int bad_hi, bad_lo;
        bad_hi = 0; bad_lo = 0;
        cfg0_idle(9, 12);
        bus0.en = 1'b1;
        step(1);
        for (int i = 0; i < 25; i++) begin
            if (bus0.tick_o !== 1'b1) bad_hi++;
            step(1);
        end
        checks++; if (bad_hi !== 0) begin errors++; $display("FAIL width_over_period: %0d low cycles, exp 0", bad_hi); end
        bus0.en = 1'b0;
        step(1);
        cfg0_idle(9, 0);
        bus0.en = 1'b1;
        step(1);
        for (int i = 0; i < 25; i++) begin
            if (bus0.tick_o !== 1'b0) bad_lo++;
            step(1);
        end
        checks++; if (bad_lo !== 0) begin errors++; $display("FAIL width_zero: %0d high cycles, exp 0", bad_lo); end
        bus0.en = 1'b0;
        step(1);
    endtask

    // Finishing stop: en sampled low at cnt 3 -> cnt 4..9 in DRAIN, then IDLE.
    task automatic test_drain();
        int bad, drain_cycles;
        sync_state_e exp_state;
        logic exp_tick;
        bad = 0; drain_cycles = 0;
        cfg1_idle(9, 3);
        bus1.en = 1'b1;
        step(1);
        for (int i = 0; i < 12; i++) begin
            exp_state = (i <= 3) ? RUN : (i <= 9) ? DRAIN : IDLE;
            exp_tick  = (i < 3);
            if (dbg1 == DRAIN) drain_cycles++;
            if (dbg1 !== exp_state || bus1.tick_o !== exp_tick || bus1.sel_idx !== 2'd0) begin
                if (bad == 0)
                    $display("FAIL drain_cycle%0d: state %0d tick %b sel %0d, exp state %0d tick %b sel 0",
                             i, dbg1, bus1.tick_o, bus1.sel_idx, exp_state, exp_tick);
                bad++;
            end
            if (i == 3) bus1.en = 1'b0;
            step(1);
        end
        checks++; if (bad !== 0)          begin errors++; $display("FAIL drain_pattern: %0d bad cycles, exp 0", bad); end
        checks++; if (drain_cycles !== 6) begin errors++; $display("FAIL drain_length: got %0d exp 6", drain_cycles); end
    endtask

    // en drops at cnt 3 and returns at cnt 7: counting and scan carry on.
    task automatic test_drain_resume();
        int bad, waited;
        sync_state_e exp_state;
        logic exp_tick, exp_frame;
        logic [1:0] exp_sel;
        bad = 0;
        bus1.en = 1'b1;
        step(1);
        for (int i = 0; i < 22; i++) begin
            exp_state = (i >= 4 && i <= 7) ? DRAIN : RUN;
            exp_tick  = (i % 10) < 3;
            exp_sel   = 2'(i / 10);
            exp_frame = (i == 0);
            if (dbg1 !== exp_state || bus1.tick_o !== exp_tick ||
                bus1.sel_idx !== exp_sel || bus1.frame_o !== exp_frame) begin
                if (bad == 0)
                    $display("FAIL resume_cycle%0d: state %0d tick %b sel %0d frame %b, exp state %0d tick %b sel %0d frame %b",
                             i, dbg1, bus1.tick_o, bus1.sel_idx, bus1.frame_o,
                             exp_state, exp_tick, exp_sel, exp_frame);
                bad++;
            end
            if (i == 3) bus1.en = 1'b0;
            if (i == 7) bus1.en = 1'b1;
            step(1);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL resume_pattern: %0d bad cycles, exp 0", bad); end
        bus1.en = 1'b0;
        waited = 0;
        while (dbg1 !== IDLE && waited < 20) begin
            step(1);
            waited++;
        end
        checks++; if (waited !== 8) begin errors++; $display("FAIL resume_drain_to_idle: took %0d cycles exp 8", waited); end
    endtask

    // Asynchronous reset mid-period with a configuration still pending.
    task automatic test_reset_mid();
        int bad;
        bad = 0;
        cfg0_idle(9, 9);
        bus0.en = 1'b1;
        step(6);
        bus0.cfg_period = 16'd4;
        bus0.cfg_width  = 8'd1;
        bus0.cfg_valid  = 1'b1;
        step(1);
        bus0.cfg_valid  = 1'b0;
        checks++; if (bus0.cfg_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b exp 0", bus0.cfg_ready); end
        step(1);
        checks++; if (bus0.tick_o !== 1'b1) begin errors++; $display("FAIL rstmid_tick_pre: got %b exp 1", bus0.tick_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dbg0 !== IDLE)               begin errors++; $display("FAIL rstmid_state: got %0d exp %0d", dbg0, IDLE); end
        checks++; if (bus0.tick_o !== 1'b0)        begin errors++; $display("FAIL rstmid_tick: got %b exp 0", bus0.tick_o); end
        checks++; if (bus0.cfg_ready !== 1'b1)     begin errors++; $display("FAIL rstmid_ready: got %b exp 1", bus0.cfg_ready); end
        checks++; if (bus0.sel_onehot !== 4'b0001) begin errors++; $display("FAIL rstmid_onehot: got %b exp 0001", bus0.sel_onehot); end
        checks++; if (bus0.frame_o !== 1'b0)       begin errors++; $display("FAIL rstmid_frame: got %b exp 0", bus0.frame_o); end
        #2;
        rst_n = 1'b1;
        step(1);
        for (int i = 0; i < 20; i++) begin
            if (bus0.tick_o !== (i < 2) || bus0.sel_idx !== 2'd0 ||
                bus0.cfg_ready !== 1'b1 || dbg0 !== RUN) begin
                if (bad == 0)
                    $display("FAIL rstmid_cycle%0d: tick %b sel %0d ready %b state %0d, exp tick %b sel 0 ready 1 state %0d",
                             i, bus0.tick_o, bus0.sel_idx, bus0.cfg_ready, dbg0, (i < 2), RUN);
                bad++;
            end
            step(1);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_after: %0d bad cycles, exp 0", bad); end
        bus0.en = 1'b0;
        step(1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus0.en = 1'b0; bus0.cfg_valid = 1'b0; bus0.cfg_period = '0; bus0.cfg_width = '0;
        bus1.en = 1'b0; bus1.cfg_valid = 1'b0; bus1.cfg_period = '0; bus1.cfg_width = '0;
        test_reset();
        test_default_run();
        test_cfg_idle();
        test_stop_immediate();
        test_cfg_run();
        test_cfg_wrap();
        test_width_extremes();
        test_drain();
        test_drain_resume();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
